brs_cond_xor_decoder: RTL and testbench
=======================================

Name: brs_cond_xor_decoder

Overview:
Receive-side companion to the BRS conditional XOR/AND combiner, where C = A^B if A[7]=0 and C = A&B if A[7]=1. The block accepts a key byte A and then one or more coded bytes C over the Tiny Tapeout pins, and recovers the plaintext byte B.
- XOR mode (A[7]=0): recovery is exact, B = A^C.
- AND mode (A[7]=1): recovery is partial, and the block flags every result whose bits cannot be recovered.
- Instantiated as the tile top; a registered FSM with a one-cycle result pipeline.

Parameters:
STREAM_EN, 1, when 1 uio_in[2] (key_hold) is honoured; when 0 the key is always consumed by one C byte.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
ena  in  1  tile enable; ignored (tied into unused-reduction wire).
ui_in  in  8  data byte (key A or coded C).
uio_in  in  8  [0] in_valid, [1] sel (0=key A, 1=coded C), [2] key_hold, [7:3] unused.
uo_out  out  8  recovered byte B (registered).
uio_out  out  8  [7] out_valid, [6] ambig, [5] proto_err, [4] key_loaded, [3:0] driven 0.
uio_oe  out  8  constant 8'hF0.

Behaviour:
- Reset: rst_n sampled low on a clk edge clears the following. Reset has priority over every other event, including mid-stream; any in-flight result is discarded.
  - State to IDLE.
  - Key register, uo_out and all uio_out bits to 0.
- Inputs are sampled only on rising clk edges where in_valid=1. in_valid=0 means no state change; out_valid deasserts.
- FSM states: IDLE (no key), KEY (key held).
- In IDLE:
  - sel=0: load key <= ui_in, go to KEY, clear proto_err.
  - sel=1: set proto_err (sticky), stay in IDLE, no output.
- In KEY:
  - sel=0: replace key with ui_in, stay in KEY, clear proto_err.
  - sel=1: decode (see below). Next state is KEY if (STREAM_EN && key_hold), otherwise IDLE.
- Decode is registered; results are visible the cycle after the sampling edge (latency 1).
  - XOR mode, key[7]=0: uo_out <= key ^ ui_in; ambig <= 0.
  - AND mode, key[7]=1: uo_out <= key & ui_in (unknown bits forced 0); ambig <= (key != 8'hFF).
- out_valid: high for exactly one cycle per decode. Back-to-back C bytes in stream mode give out_valid high on consecutive cycles.
- Holding behaviour:
  - uo_out and ambig hold their last value until the next decode.
  - proto_err holds until the next key load or reset.
- key_loaded = (state==KEY), registered with the state.
- Simultaneous events: one byte per cycle by construction. The key used for a decode is always the key loaded on a strictly earlier edge.
- ui_in is not registered except into the key or output register.
- uio_out[3:0] = 0 and uio_oe = 8'hF0 at all times, including during reset.

Test Plan:
1. XOR decode: reset, key A=0x35, then C=0x6F (key_hold=0) -> next cycle uo_out=0x5A, out_valid=1 for one cycle, ambig=0, key_loaded=0.
2. AND partial decode: key A=0xF0, C=0x30 -> uo_out=0x30, ambig=1. Then key A=0xFF, C=0xA5 -> uo_out=0xA5, ambig=0.
3. Stream mode (STREAM_EN=1): key A=0x0F, then C=0x00, 0xFF, 0x5A on consecutive cycles with key_hold=1 -> uo_out=0x0F, 0xF0, 0x55, out_valid high 3 consecutive cycles, key_loaded stays 1. With STREAM_EN=0 the same sequence gives only 0x0F, then proto_err=1 on the second C byte.
4. Protocol error: C=0x12 from IDLE -> proto_err=1, out_valid=0, uo_out unchanged (0x00). Loading key 0x01 clears proto_err.
5. Key replace and idle gaps: key 0x11, key 0x22, two idle cycles, C=0x22 -> uo_out=0x00 (uses 0x22); out_valid stays 0 during the idle cycles.
6. Reset mid-operation: key 0x35 loaded, C=0x6F presented on the same edge rst_n=0 -> no out_valid, uo_out=0x00, key_loaded=0. After release, C=0x6F -> proto_err=1.

Source files
------------

// File: rtl/brs_cond_xor_decoder.sv
// Receive-side decoder for the BRS conditional XOR/AND combiner: recovers B from key A and coded C.
// Latency 1 cycle from the sampling edge; no backpressure, one byte accepted per in_valid cycle.
module brs_cond_xor_decoder #(
    parameter bit STREAM_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic {IDLE = 1'b0, KEY = 1'b1} state_t;

    state_t     state;
    logic [7:0] key;
    logic [7:0] plain;
    logic       out_valid;
    logic       ambig;
    logic       proto_err;

    logic in_valid;
    logic sel;
    logic key_hold;

    assign in_valid = uio_in[0];
    assign sel      = uio_in[1];
    assign key_hold = uio_in[2];

    wire unused_ok = &{1'b0, ena, uio_in[7:3]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            key       <= 8'h00;
            plain     <= 8'h00;
            out_valid <= 1'b0;
            ambig     <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (!sel) begin
                    key       <= ui_in;
                    state     <= KEY;
                    proto_err <= 1'b0;
                end else if (state == IDLE) begin
                    proto_err <= 1'b1;
                end else begin
                    // AND mode loses every bit where the key is 0; those are reported as 0 and flagged
                    plain     <= key[7] ? (key & ui_in) : (key ^ ui_in);
                    ambig     <= key[7] && (key != 8'hFF);
                    out_valid <= 1'b1;
                    state     <= (STREAM_EN && key_hold) ? KEY : IDLE;
                end
            end
        end
    end

    assign uo_out  = plain;
    assign uio_out = {out_valid, ambig, proto_err, (state == KEY), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_brs_cond_xor_decoder.sv
// Directed bench for brs_cond_xor_decoder, comparing stream-enabled and stream-disabled builds.
module tb_brs_cond_xor_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo0, uio0, oe0;
    logic [7:0] uo1, uio1, oe1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brs_cond_xor_decoder #(.STREAM_EN(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo0), .uio_out(uio0), .uio_oe(oe0)
    );

    brs_cond_xor_decoder #(.STREAM_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs at a falling edge, return at the next falling edge.
    task automatic step(input logic r, input logic v, input logic s, input logic h,
                        input logic [7:0] d);
        rst_n  = r;
        uio_in = {5'b00000, h, s, v};
        ui_in  = d;
        @(negedge clk);
    endtask

    task automatic key(input logic [7:0] d);
        step(1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic code(input logic h, input logic [7:0] d);
        step(1'b1, 1'b1, 1'b1, h, d);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        @(negedge clk);
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_uo", uo0, 8'h00);
        check("rst_uio", uio0, 8'h00);
        check("rst_oe", oe0, 8'hF0);
        check("rst_uio_n", uio1, 8'h00);

        // 1: XOR decode
        key(8'h35);
        check("t1_key_loaded", {7'b0, uio0[4]}, 8'h01);
        code(1'b0, 8'h6F);
        check("t1_uo", uo0, 8'h5A);
        check("t1_uio", uio0, 8'h80);
        idle();
        check("t1_valid_drop", {7'b0, uio0[7]}, 8'h00);
        check("t1_uo_hold", uo0, 8'h5A);

        // 2: AND partial, then full key
        key(8'hF0);
        code(1'b0, 8'h30);
        check("t2_uo_part", uo0, 8'h30);
        check("t2_uio_part", uio0, 8'hC0);
        idle();
        check("t2_ambig_hold", {7'b0, uio0[6]}, 8'h01);
        key(8'hFF);
        code(1'b0, 8'hA5);
        check("t2_uo_full", uo0, 8'hA5);
        check("t2_uio_full", uio0, 8'h80);

        // 3: stream mode vs stream disabled
        key(8'h0F);
        code(1'b1, 8'h00);
        check("t3_s_uo0", uo0, 8'h0F);
        check("t3_s_uio0", uio0, 8'h90);
        check("t3_n_uo0", uo1, 8'h0F);
        check("t3_n_uio0", uio1, 8'h80);
        code(1'b1, 8'hFF);
        check("t3_s_uo1", uo0, 8'hF0);
        check("t3_s_uio1", uio0, 8'h90);
        check("t3_n_uo1", uo1, 8'h0F);
        check("t3_n_uio1", uio1, 8'h20);
        code(1'b1, 8'h5A);
        check("t3_s_uo2", uo0, 8'h55);
        check("t3_s_uio2", uio0, 8'h90);
        idle();
        check("t3_s_idle", uio0, 8'h10);

        // 4: protocol error from IDLE
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        code(1'b0, 8'h12);
        check("t4_uo", uo0, 8'h00);
        check("t4_uio", uio0, 8'h20);
        idle();
        check("t4_err_sticky", uio0, 8'h20);
        key(8'h01);
        check("t4_err_clear", uio0, 8'h10);

        // 5: key replace with idle gaps
        key(8'h11);
        key(8'h22);
        idle();
        check("t5_idle1", uio0, 8'h10);
        idle();
        check("t5_idle2", uio0, 8'h10);
        code(1'b0, 8'h22);
        check("t5_uo", uo0, 8'h00);
        check("t5_uio", uio0, 8'h80);

        // 6: reset while a coded byte is presented
        key(8'h35);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h6F);
        check("t6_uo", uo0, 8'h00);
        check("t6_uio", uio0, 8'h00);
        check("t6_oe", oe0, 8'hF0);
        code(1'b0, 8'h6F);
        check("t6_after_uio", uio0, 8'h20);
        check("t6_after_uo", uo0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
